// File: rtl/cpu_pkg.sv
//==============================================================
// cpu_pkg - shared widths and the fetch buffer entry type (rev 1.0)
//==============================================================
`default_nettype none

package cpu_pkg;
  localparam int DataSize  = 32;
  localparam int PCsize    = 6;
  localparam int FifoDepth = 4;
  localparam int CntW      = 3;

  typedef struct packed {
    logic [DataSize-1:0] instr;
    logic [PCsize-1:0]   pc;
  } fetch_entry;
endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//==============================================================
// fetch_fifo - synchronous FIFO with flush and zeroed head when empty (rev 1.0)
//==============================================================
`default_nettype none

module fetch_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4,
  parameter int CntW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CntW-1:0]  count_o,
  output logic [Width-1:0] head_o
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != CntW'(Depth));

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head reads as zero when empty so downstream never sees stale data.
  assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================
// fetch_unit - PC, credit, redirect/drop control for instruction fetch (rev 1.0)
//==============================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DataSize  = cpu_pkg::DataSize,
  parameter int PCsize    = cpu_pkg::PCsize,
  parameter int FifoDepth = cpu_pkg::FifoDepth,
  parameter int CntW      = cpu_pkg::CntW
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PCsize-1:0]   imem_addr,
  input  logic                imem_valid,
  input  logic [DataSize-1:0] imem_rdata,
  input  logic                redirect_valid,
  input  logic [PCsize-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DataSize-1:0] out_instr,
  output logic [PCsize-1:0]   out_pc,
  output logic [CntW-1:0]     fifo_count
);
  logic [PCsize-1:0] pc_q, pc_d, tag_head;
  logic [CntW-1:0]   drop_q, drop_d, outstanding;
  logic [CntW:0]     credit_used;
  logic              resp_keep;
  fetch_entry        push_entry, head_entry;

  // The tag queue holds exactly one entry per in-flight request, so its
  // occupancy is the outstanding count.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = rst && !redirect_valid && (credit_used < (CntW+1)'(FifoDepth));
  assign imem_addr   = pc_q;
  assign resp_keep   = imem_valid && (drop_q == '0) && !redirect_valid;
  assign push_entry  = '{instr: imem_rdata, pc: tag_head};

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = outstanding - CntW'(imem_valid);
    end else begin
      if (imem_req) pc_d = pc_q + PCsize'(1);
      if (imem_valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .Width ($bits(fetch_entry)),
    .Depth (FifoDepth),
    .CntW  (CntW)
  ) u_instr_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (resp_keep),
    .push_data_i (push_entry),
    .pop_i       (out_valid && out_ready),
    .flush_i     (redirect_valid),
    .count_o     (fifo_count),
    .head_o      (head_entry)
  );

  // Never flushed: responses for redirected requests still arrive and must pop.
  fetch_fifo #(
    .Width (PCsize),
    .Depth (FifoDepth),
    .CntW  (CntW)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (imem_req),
    .push_data_i (pc_q),
    .pop_i       (imem_valid),
    .flush_i     (1'b0),
    .count_o     (outstanding),
    .head_o      (tag_head)
  );

  assign out_valid = (fifo_count != '0);
  assign out_instr = head_entry.instr;
  assign out_pc    = head_entry.pc;
endmodule

`default_nettype wire
